// File: rtl/jh_grid_feeder.sv
// ============================================================================
// Module      : jh_grid_feeder
// Description : Row-major sweep controller feeding neighbour stencils to the
//               jh_efield FDTD kernel and writing results back by address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jh_grid_feeder #(
  parameter int NR  = 4,
  parameter int NZ  = 5,
  parameter int AW  = 10,
  parameter int LAT = 5
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [26:0]   rd_data,
  output logic [AW-1:0] rc_addr,
  input  logic [26:0]   rc_data,
  output logic [26:0]   V_top,
  output logic [26:0]   V_bottom,
  output logic [26:0]   V_left,
  output logic [26:0]   V_right,
  output logic [26:0]   r,
  output logic          k_valid,
  input  logic [26:0]   fdtd_result,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [26:0]   wr_data
);

  localparam logic [AW-1:0] C_NZ    = AW'(NZ);
  localparam logic [AW-1:0] C_JLAST = AW'(NZ - 2);
  localparam logic [AW-1:0] C_ILAST = AW'(NR - 2);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ROW_PRE = 2'd1,
    S_NODE    = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_ph;
  logic [AW-1:0] r_i, r_j, r_base;
  logic [26:0]   r_row;

  // Tags describing what the read issued last cycle returns this cycle
  logic          w_rd_row, w_rd_top, w_rd_bot, w_rd_issue;
  logic          r_d_row, r_d_top, r_d_bot, r_d_issue;
  logic [AW-1:0] r_d_addr;

  logic [26:0]   r_top_h, r_bot_h, r_sr_left, r_sr_mid;
  logic [26:0]   r_vt, r_vb, r_vl, r_vr, r_rout;
  logic          r_kv;
  logic [AW-1:0] r_ka;

  logic [LAT-1:0] r_pv;
  logic [AW-1:0]  r_pa [LAT];
  logic           w_pipe_busy;

  assign w_pipe_busy = r_d_issue | r_kv | (|r_pv);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    rd_addr     = '0;
    w_rd_row    = 1'b0;
    w_rd_top    = 1'b0;
    w_rd_bot    = 1'b0;
    w_rd_issue  = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_ROW_PRE;
      end
      S_ROW_PRE: begin
        rd_en    = 1'b1;
        rd_addr  = r_base + AW'(r_ph);
        w_rd_row = 1'b1;
        if (r_ph == 2'd1) w_state_nxt = S_NODE;
      end
      S_NODE: begin
        rd_en = 1'b1;
        case (r_ph)
          2'd0: begin
            rd_addr  = r_base + C_NZ + r_j;
            w_rd_top = 1'b1;
          end
          2'd1: begin
            rd_addr  = r_base - C_NZ + r_j;
            w_rd_bot = 1'b1;
          end
          default: begin
            rd_addr    = r_base + r_j + AW'(1);
            w_rd_row   = 1'b1;
            w_rd_issue = 1'b1;
            if (r_j == C_JLAST)
              w_state_nxt = (r_i == C_ILAST) ? S_DRAIN : S_ROW_PRE;
          end
        endcase
      end
      default: begin
        if (!w_pipe_busy) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Sweep counters; r_base tracks i*NZ so no multiplier is needed
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_ph   <= '0;
      r_i    <= '0;
      r_j    <= '0;
      r_base <= '0;
      r_row  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_i    <= AW'(1);
            r_base <= C_NZ;
            r_ph   <= '0;
          end
        end
        S_ROW_PRE: begin
          if (r_ph == 2'd0) begin
            r_ph <= 2'd1;
          end else begin
            r_ph  <= '0;
            r_j   <= AW'(1);
            r_row <= rc_data;
          end
        end
        S_NODE: begin
          if (r_ph != 2'd2) begin
            r_ph <= r_ph + 2'd1;
          end else begin
            r_ph <= '0;
            if (r_j != C_JLAST) begin
              r_j <= r_j + AW'(1);
            end else if (r_i != C_ILAST) begin
              r_i    <= r_i + AW'(1);
              r_base <= r_base + C_NZ;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_d_row   <= 1'b0;
      r_d_top   <= 1'b0;
      r_d_bot   <= 1'b0;
      r_d_issue <= 1'b0;
      r_d_addr  <= '0;
      r_top_h   <= '0;
      r_bot_h   <= '0;
      r_sr_left <= '0;
      r_sr_mid  <= '0;
      r_vt      <= '0;
      r_vb      <= '0;
      r_vl      <= '0;
      r_vr      <= '0;
      r_rout    <= '0;
      r_kv      <= 1'b0;
      r_ka      <= '0;
      r_pv      <= '0;
      for (int s = 0; s < LAT; s++) r_pa[s] <= '0;
    end else begin
      r_d_row   <= w_rd_row;
      r_d_top   <= w_rd_top;
      r_d_bot   <= w_rd_bot;
      r_d_issue <= w_rd_issue;
      if (w_rd_issue) r_d_addr <= r_base + r_j;
      if (r_d_top) r_top_h <= rd_data;
      if (r_d_bot) r_bot_h <= rd_data;
      if (r_d_row) begin
        r_sr_left <= r_sr_mid;
        r_sr_mid  <= rd_data;
      end
      // Left comes from the pre-shift register: it still holds (i,j-1) here
      r_kv <= r_d_issue;
      if (r_d_issue) begin
        r_vt   <= r_top_h;
        r_vb   <= r_bot_h;
        r_vl   <= r_sr_left;
        r_vr   <= rd_data;
        r_rout <= r_row;
        r_ka   <= r_d_addr;
      end
      for (int s = LAT - 1; s > 0; s--) begin
        r_pv[s] <= r_pv[s-1];
        r_pa[s] <= r_pa[s-1];
      end
      r_pv[0] <= r_kv;
      r_pa[0] <= r_ka;
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign rc_addr  = r_i;
  assign V_top    = r_vt;
  assign V_bottom = r_vb;
  assign V_left   = r_vl;
  assign V_right  = r_vr;
  assign r        = r_rout;
  assign k_valid  = r_kv;
  assign wr_en    = r_pv[LAT-1];
  assign wr_addr  = r_pa[LAT-1];
  assign wr_data  = r_pv[LAT-1] ? fdtd_result : '0;

endmodule

`default_nettype wire

// File: tb/tb_jh_grid_feeder.sv
// ============================================================================
// Module      : tb_jh_grid_feeder
// Description : Directed, table-driven bench for jh_grid_feeder (4x5 and 3x3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jh_grid_feeder;

  localparam int AW  = 10;
  localparam int LAT = 5;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- 4x5 instance ----------------
  logic          start = 1'b0;
  logic          busy, done, rd_en, k_valid, wr_en;
  logic [AW-1:0] rd_addr, rc_addr, wr_addr;
  logic [26:0]   rd_data = '0, rc_data = '0, fdtd_result;
  logic [26:0]   V_top, V_bottom, V_left, V_right, r_c, wr_data;

  jh_grid_feeder #(.NR(4), .NZ(5), .AW(AW), .LAT(LAT)) u_dut (
    .clock(clock), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rc_addr(rc_addr), .rc_data(rc_data),
    .V_top(V_top), .V_bottom(V_bottom), .V_left(V_left), .V_right(V_right),
    .r(r_c), .k_valid(k_valid), .fdtd_result(fdtd_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // ---------------- 3x3 instance ----------------
  logic          start_m = 1'b0;
  logic          busy_m, done_m, rd_en_m, k_valid_m, wr_en_m;
  logic [AW-1:0] rd_addr_m, rc_addr_m, wr_addr_m;
  logic [26:0]   rd_data_m = '0, rc_data_m = '0, fdtd_result_m;
  logic [26:0]   V_top_m, V_bottom_m, V_left_m, V_right_m, r_m, wr_data_m;

  jh_grid_feeder #(.NR(3), .NZ(3), .AW(AW), .LAT(LAT)) u_min (
    .clock(clock), .rst(rst), .start(start_m), .busy(busy_m), .done(done_m),
    .rd_en(rd_en_m), .rd_addr(rd_addr_m), .rd_data(rd_data_m),
    .rc_addr(rc_addr_m), .rc_data(rc_data_m),
    .V_top(V_top_m), .V_bottom(V_bottom_m), .V_left(V_left_m), .V_right(V_right_m),
    .r(r_m), .k_valid(k_valid_m), .fdtd_result(fdtd_result_m),
    .wr_en(wr_en_m), .wr_addr(wr_addr_m), .wr_data(wr_data_m)
  );

  // Memories: word = address; r table = 100 + row. Kernel returns issue tag after LAT.
  logic [26:0] ks [LAT];
  logic [26:0] ks_m [LAT];
  logic [26:0] kcnt, kcnt_m;

  always @(posedge clock) begin
    if (rd_en)   rd_data   <= 27'(rd_addr);
    if (rd_en_m) rd_data_m <= 27'(rd_addr_m);
    rc_data   <= 27'd100 + 27'(rc_addr);
    rc_data_m <= 27'd100 + 27'(rc_addr_m);
  end

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      kcnt   <= '0;
      kcnt_m <= '0;
      for (int q = 0; q < LAT; q++) begin
        ks[q]   <= '0;
        ks_m[q] <= '0;
      end
    end else begin
      if (start && !busy)      kcnt <= '0;
      else if (k_valid)        kcnt <= kcnt + 27'd1;
      if (start_m && !busy_m)  kcnt_m <= '0;
      else if (k_valid_m)      kcnt_m <= kcnt_m + 27'd1;
      ks[0]   <= k_valid   ? kcnt   : 27'h0;
      ks_m[0] <= k_valid_m ? kcnt_m : 27'h0;
      for (int q = 1; q < LAT; q++) begin
        ks[q]   <= ks[q-1];
        ks_m[q] <= ks_m[q-1];
      end
    end
  end
  assign fdtd_result   = ks[LAT-1];
  assign fdtd_result_m = ks_m[LAT-1];

  // ---------------- event logs ----------------
  typedef struct { int cyc; logic [26:0] t, b, l, rt, rc; } kev_t;
  typedef struct { int cyc; int a; logic [26:0] d; } wev_t;

  kev_t kq[$];  wev_t wq[$];  int dq[$];
  kev_t kqm[$]; wev_t wqm[$]; int dqm[$];
  int   rdq_c[$], rdq_a[$];
  int   rd_total = 0;
  logic prev_rd  = 1'b0;

  always @(negedge clock) begin
    if (k_valid) kq.push_back('{cyc, V_top, V_bottom, V_left, V_right, r_c});
    if (wr_en)   wq.push_back('{cyc, int'(wr_addr), wr_data});
    if (done)    dq.push_back(cyc);
    if (rd_en)   rd_total = rd_total + 1;
    if (rd_en && !prev_rd) begin
      rdq_c.push_back(cyc);
      rdq_a.push_back(int'(rd_addr));
    end
    prev_rd = rd_en;
    if (k_valid_m) kqm.push_back('{cyc, V_top_m, V_bottom_m, V_left_m, V_right_m, r_m});
    if (wr_en_m)   wqm.push_back('{cyc, int'(wr_addr_m), wr_data_m});
    if (done_m)    dqm.push_back(cyc);
  end

  // ---------------- checking ----------------
  typedef struct {
    int k_cyc; int top; int bot; int left; int right; int rco;
    int w_cyc; int w_addr; int tag;
  } vec_t;
  vec_t tbl [6];

  int n_vec = 0;
  int n_bad = 0;
  int s0    = 0;
  int s0m   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    s0    = cyc;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int db);
    for (int w = 0; w < 300; w++) begin
      if (dq.size() > db) break;
      @(posedge clock);
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_sweep(input string tg, input int kb, input int wb,
                             input int db, input int rb, input int rdb);
    chk($sformatf("%s_kcount", tg), kq.size() - kb, 6);
    chk($sformatf("%s_wcount", tg), wq.size() - wb, 6);
    for (int v = 0; v < 6; v++) begin
      kev_t ke;
      wev_t we;
      ke = '{-1000, '0, '0, '0, '0, '0};
      we = '{-1000, -1, '0};
      if (kb + v < kq.size()) ke = kq[kb+v];
      if (wb + v < wq.size()) we = wq[wb+v];
      chk($sformatf("%s_n%0d_kcyc",   tg, v), ke.cyc - s0, tbl[v].k_cyc);
      chk($sformatf("%s_n%0d_top",    tg, v), ke.t,        tbl[v].top);
      chk($sformatf("%s_n%0d_bottom", tg, v), ke.b,        tbl[v].bot);
      chk($sformatf("%s_n%0d_left",   tg, v), ke.l,        tbl[v].left);
      chk($sformatf("%s_n%0d_right",  tg, v), ke.rt,       tbl[v].right);
      chk($sformatf("%s_n%0d_r",      tg, v), ke.rc,       tbl[v].rco);
      chk($sformatf("%s_n%0d_wcyc",   tg, v), we.cyc - s0, tbl[v].w_cyc);
      chk($sformatf("%s_n%0d_waddr",  tg, v), we.a,        tbl[v].w_addr);
      chk($sformatf("%s_n%0d_wdata",  tg, v), we.d,        tbl[v].tag);
    end
    chk($sformatf("%s_done_cyc", tg), (dq.size() > db) ? dq[db] - s0 : -1, 30);
    chk($sformatf("%s_done_once", tg), dq.size() - db, 1);
    chk($sformatf("%s_first_rd_cyc", tg), (rdq_c.size() > rb) ? rdq_c[rb] - s0 : -1, 1);
    chk($sformatf("%s_first_rd_addr", tg), (rdq_a.size() > rb) ? rdq_a[rb] : -1, 5);
    chk($sformatf("%s_rd_cycles", tg), rd_total - rdb, 22);
    chk($sformatf("%s_busy_after", tg), busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int kb, wb, db, rb, rdb, wsz, dsz;
    //          kcyc top bot lft rgt   r  wcyc waddr tag
    tbl[0] = '{ 7, 11,  1,  5,  7, 101, 12,  6, 0};
    tbl[1] = '{10, 12,  2,  6,  8, 101, 15,  7, 1};
    tbl[2] = '{13, 13,  3,  7,  9, 101, 18,  8, 2};
    tbl[3] = '{18, 16,  6, 10, 12, 102, 23, 11, 3};
    tbl[4] = '{21, 17,  7, 11, 13, 102, 26, 12, 4};
    tbl[5] = '{24, 18,  8, 12, 14, 102, 29, 13, 5};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    chk("rst_rd_en",   rd_en,   0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_k_valid", k_valid, 0);
    chk("rst_wr_en",   wr_en,   0);
    chk("rst_V_top",   V_top,   0);
    chk("rst_r",       r_c,     0);
    chk("rst_rc_addr", rc_addr, 0);
    rst = 1'b1;
    repeat (2) @(posedge clock);

    // Sweep A with a start re-pulse while busy
    kb = kq.size(); wb = wq.size(); db = dq.size(); rb = rdq_c.size(); rdb = rd_total;
    pulse_start();
    chk("A_busy_c1", busy, 1);
    repeat (3) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(db);
    check_sweep("A", kb, wb, db, rb, rdb);

    // Sweep B: identical repeat after done
    kb = kq.size(); wb = wq.size(); db = dq.size(); rb = rdq_c.size(); rdb = rd_total;
    pulse_start();
    wait_done(db);
    check_sweep("B", kb, wb, db, rb, rdb);

    // Minimum 3x3 grid
    @(posedge clock); #1;
    start_m = 1'b1;
    s0m     = cyc;
    @(posedge clock); #1;
    start_m = 1'b0;
    for (int w = 0; w < 100; w++) begin
      if (dqm.size() > 0) break;
      @(posedge clock);
    end
    repeat (2) @(posedge clock);
    #1;
    chk("min_kcount", kqm.size(), 1);
    chk("min_wcount", wqm.size(), 1);
    chk("min_done_cyc", (dqm.size() > 0) ? dqm[0] - s0m : -1, 13);
    if (kqm.size() > 0) begin
      chk("min_kcyc",   kqm[0].cyc - s0m, 7);
      chk("min_top",    kqm[0].t,  7);
      chk("min_bottom", kqm[0].b,  1);
      chk("min_left",   kqm[0].l,  3);
      chk("min_right",  kqm[0].rt, 5);
      chk("min_r",      kqm[0].rc, 101);
    end
    if (wqm.size() > 0) begin
      chk("min_wcyc",  wqm[0].cyc - s0m, 12);
      chk("min_waddr", wqm[0].a, 4);
      chk("min_wdata", wqm[0].d, 0);
    end

    // Reset asserted in cycle 15 of a sweep
    pulse_start();
    repeat (14) @(posedge clock);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_busy",    busy,     0);
    chk("mid_rst_rd_en",   rd_en,    0);
    chk("mid_rst_rd_addr", rd_addr,  0);
    chk("mid_rst_rc_addr", rc_addr,  0);
    chk("mid_rst_k_valid", k_valid,  0);
    chk("mid_rst_V_right", V_right,  0);
    chk("mid_rst_r",       r_c,      0);
    chk("mid_rst_wr_en",   wr_en,    0);
    chk("mid_rst_wr_addr", wr_addr,  0);
    chk("mid_rst_wr_data", wr_data,  0);
    wsz = wq.size();
    dsz = dq.size();
    repeat (3) @(posedge clock);
    #1 rst = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    chk("mid_rst_no_wr_after", wq.size() - wsz, 0);
    chk("mid_rst_no_done",     dq.size() - dsz, 0);

    // Full sweep after recovery
    kb = kq.size(); wb = wq.size(); db = dq.size(); rb = rdq_c.size(); rdb = rd_total;
    pulse_start();
    wait_done(db);
    check_sweep("C", kb, wb, db, rb, rdb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
